// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, access ops,
// mstatus/mip bit positions and interrupt cause codes.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [4:0] CODE_MSI = 5'd3;
  localparam logic [4:0] CODE_MTI = 5'd7;
  localparam logic [4:0] CODE_MEI = 5'd11;

  // Compact {MEI, MTI, MSI} triple -> architectural bit layout of mie/mip.
  function automatic logic [11:0] irq_bits_to_csr(input logic [2:0] b);
    logic [11:0] v;
    v = '0;
    v[MIP_MSIP] = b[0];
    v[MIP_MTIP] = b[1];
    v[MIP_MEIP] = b[2];
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose halves can be written independently;
// any write in a cycle suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count_reg[31:0]  <= wdata;
      if (wr_hi) count_reg[63:32] <= wdata;
    end else if (inc) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR access, trap entry/mret
// stacking of mstatus, interrupt selection and 64-bit cycle/instret counters.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] HARTID      = 32'd0,
  parameter logic [31:0] MVENDORID   = 32'h79737978,
  parameter logic [31:0] MARCHID     = 32'd25040129,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            irq_ok,
  input  logic [XLEN-1:0] next_pc,
  input  logic            instret,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target,
  output logic            irq_taken
);

  // Low bits are stored as written and masked on every read path.
  localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);

  csr_op_e         op;
  logic            mie_bit_reg, mpie_reg;
  logic [2:0]      mie_reg, mip_reg, pend;
  logic [XLEN-1:0] mtvec_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [XLEN-1:0] mtvec_rd, mepc_rd, mtvec_base, old_val, new_val;
  logic [63:0]     mcycle, minstret;
  logic            known, read_only, write_req, csr_we;
  logic            exc_take, irq_take, mret_take;
  logic [4:0]      irq_code;

  assign op         = csr_op_e'(csr_op);
  assign mtvec_rd   = mtvec_reg & MTVEC_MASK;
  assign mepc_rd    = mepc_reg & MEPC_MASK;
  assign mtvec_base = mtvec_rd & ~XLEN'(3);

  always_comb begin
    known     = 1'b1;
    read_only = 1'b0;
    old_val   = '0;
    case (csr_addr)
      ADDR_MSTATUS:   old_val = XLEN'({2'b11, 3'b000, mpie_reg, 3'b000, mie_bit_reg, 3'b000});
      ADDR_MIE:       old_val = XLEN'(irq_bits_to_csr(mie_reg));
      ADDR_MTVEC:     old_val = mtvec_rd;
      ADDR_MEPC:      old_val = mepc_rd;
      ADDR_MCAUSE:    old_val = mcause_reg;
      ADDR_MTVAL:     old_val = mtval_reg;
      ADDR_MCYCLE:    old_val = XLEN'(mcycle[31:0]);
      ADDR_MCYCLEH:   old_val = XLEN'(mcycle[63:32]);
      ADDR_MINSTRET:  old_val = XLEN'(minstret[31:0]);
      ADDR_MINSTRETH: old_val = XLEN'(minstret[63:32]);
      ADDR_MIP: begin
        read_only = 1'b1;
        old_val   = XLEN'(irq_bits_to_csr(mip_reg));
      end
      ADDR_MVENDORID: begin read_only = 1'b1; old_val = XLEN'(MVENDORID); end
      ADDR_MARCHID:   begin read_only = 1'b1; old_val = XLEN'(MARCHID);   end
      ADDR_MIMPID:    begin read_only = 1'b1; old_val = '0;               end
      ADDR_MHARTID:   begin read_only = 1'b1; old_val = XLEN'(HARTID);    end
      default:        known = 1'b0;
    endcase
  end

  always_comb begin
    new_val = csr_wdata;
    case (op)
      CSR_RS:  new_val = old_val | csr_wdata;
      CSR_RC:  new_val = old_val & ~csr_wdata;
      default: new_val = csr_wdata;
    endcase
  end

  // RS/RC with a zero operand are pure reads and can never fault.
  assign write_req   = (op == CSR_RW) ||
                       (((op == CSR_RS) || (op == CSR_RC)) && (csr_wdata != '0));
  assign csr_rdata   = old_val;
  assign csr_illegal = write_req && (!known || read_only);

  assign pend     = mip_reg & mie_reg;
  assign irq_code = pend[2] ? CODE_MEI : (pend[0] ? CODE_MSI : CODE_MTI);

  assign exc_take  = !rst && exc_valid;
  assign irq_take  = !rst && irq_ok && mie_bit_reg && (pend != 3'b000) && !exc_valid;
  assign mret_take = !rst && mret && !exc_valid && !irq_take;
  assign csr_we    = !rst && write_req && known && !read_only &&
                     !exc_valid && !irq_take && !mret;

  always_comb begin
    trap_target = mtvec_base;
    if (irq_take && VECTORED_EN && mtvec_rd[0])
      trap_target = mtvec_base + XLEN'({irq_code, 2'b00});
    else if (mret_take)
      trap_target = mepc_rd;
  end

  assign trap_redirect = exc_take || irq_take || mret_take;
  assign irq_taken     = irq_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit_reg <= 1'b0;
      mpie_reg    <= 1'b0;
      mie_reg     <= '0;
      mip_reg     <= '0;
      mtvec_reg   <= '0;
      mepc_reg    <= '0;
      mcause_reg  <= '0;
      mtval_reg   <= '0;
    end else begin
      mip_reg <= {irq_ext, irq_timer, irq_sw};
      if (exc_take || irq_take) begin
        mepc_reg    <= exc_valid ? exc_pc : next_pc;
        mcause_reg  <= exc_valid ? XLEN'(exc_cause) : XLEN'(irq_code);
        if (!exc_valid) mcause_reg[XLEN-1] <= 1'b1;
        mtval_reg   <= exc_valid ? exc_tval : '0;
        mpie_reg    <= mie_bit_reg;
        mie_bit_reg <= 1'b0;
      end else if (mret_take) begin
        mie_bit_reg <= mpie_reg;
        mpie_reg    <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mie_bit_reg <= new_val[MSTATUS_MIE];
            mpie_reg    <= new_val[MSTATUS_MPIE];
          end
          ADDR_MIE:    mie_reg    <= {new_val[MIP_MEIP], new_val[MIP_MTIP], new_val[MIP_MSIP]};
          ADDR_MTVEC:  mtvec_reg  <= new_val;
          ADDR_MEPC:   mepc_reg   <= new_val;
          ADDR_MCAUSE: mcause_reg <= new_val;
          ADDR_MTVAL:  mtval_reg  <= new_val;
          default: ;
        endcase
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_we && (csr_addr == ADDR_MCYCLE)),
    .wr_hi (csr_we && (csr_addr == ADDR_MCYCLEH)),
    .wdata (new_val[31:0]),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret),
    .wr_lo (csr_we && (csr_addr == ADDR_MINSTRET)),
    .wr_hi (csr_we && (csr_addr == ADDR_MINSTRETH)),
    .wdata (new_val[31:0]),
    .count (minstret)
  );

endmodule
